tick_period_monitor: RTL
========================

// Module: tick_period_monitor
// PURPOSE
//   Receive-side checker for a periodic single-tick source, e.g. a mod-N counter terminal pulse.
//   Measures CLOCK cycles between successive rising edges of tick_in.
//   Declares lock after LOCK_COUNT consecutive in-tolerance intervals.
//   Flags and counts bad or missing ticks. Sits beside the tick generator as an in-system health monitor.
// PARAMETERS
//   PERIOD     100  expected interval, in CLOCK cycles
//   TOL        0    allowed deviation: good interval is PERIOD-TOL .. PERIOD+TOL
//   LOCK_COUNT 3    consecutive good intervals needed to assert locked
//   CW         8    interval counter / period width; PERIOD+TOL+1 must be <= 2^CW-1
// PORTS
//   CLOCK        in   1   system clock, rising edge
//   RESET        in   1   asynchronous, active-high reset
//   tick_in      in   1   tick from source, synchronous to CLOCK; rising edge is the event
//   period       out  CW  last measured interval, in cycles
//   period_valid out  1   one-cycle strobe: period updated
//   locked       out  1   high while FSM is in LOCKED
//   err_pulse    out  1   one-cycle strobe on bad or missing tick while LOCKED
//   err_count    out  8   error total, saturates at 255
// BEHAVIOUR
//   Reset:
//   - RESET=1 immediately clears all outputs to 0, the FSM to IDLE, cnt, good_cnt and tick_q.
//   Edge detect:
//   - edge = tick_in & ~tick_q, where tick_q is tick_in registered.
//   - A level held high for several cycles gives exactly one edge.
//   Interval counter cnt:
//   - On an edge, cnt <= 1. Otherwise cnt increments, saturating at 2^CW-1.
//   - Edges at cycles t and t+100 measure 100.
//   Measurement:
//   - On each edge except the first after IDLE: period <= cnt and period_valid=1.
//   - Both appear on the cycle after the edge is sampled (1-cycle latency).
//   - good = (cnt >= PERIOD-TOL) && (cnt <= PERIOD+TOL).
//   FSM states and transitions:
//   - IDLE: on an edge, go to ACQUIRE with good_cnt=0. No period_valid for this first edge.
//   - ACQUIRE, edge and good: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED.
//   - ACQUIRE, edge and bad: good_cnt <= 0 and stay in ACQUIRE. No error is raised.
//   - ACQUIRE, timeout (cnt==PERIOD+TOL+1 with no edge): go to IDLE. No error is raised.
//   - LOCKED, edge and good: stay.
//   - LOCKED, edge and bad: err_pulse, err_count++, good_cnt <= 0, go to ACQUIRE.
//   - LOCKED, timeout: err_pulse, err_count++, go to IDLE.
//   locked timing:
//   - locked = (state==LOCKED), registered.
//   - It rises on the same cycle as the period_valid of the LOCK_COUNT-th good interval.
//   Simultaneous events:
//   - An edge on the timeout cycle is handled as an edge.
//   - Its interval PERIOD+TOL+1 is bad, so a LOCKED FSM goes to ACQUIRE, not IDLE.
//   - Only one error is counted.
//   Saturation:
//   - err_count stays at 255. err_pulse still fires.
//   Reset mid-operation:
//   - Async clear of everything.
//   - The first edge after reset release is treated as the IDLE first edge.
// TESTING (PERIOD=100, TOL=0, LOCK_COUNT=3 unless stated)
//   1. Reset, then tick_in pulses every 100 cycles.
//      -> period=100 with period_valid on edges 2..n; locked rises with edge 4's strobe; err_count=0.
//   2. Locked, then one interval of 99 cycles.
//      -> period=99, err_pulse for 1 cycle, err_count=1, locked=0; relock 3 good intervals later.
//   3. Locked, then ticks stop.
//      -> err_pulse 101 cycles after the last edge, state IDLE, locked=0, err_count+1.
//   4. tick_in held high 5 cycles, every 100 cycles.
//      -> one edge per pulse; period=100; locked behaves as in test 1.
//   5. TOL=1, intervals 101,99,100.
//      -> all good, locked=1, err_count=0. Then interval 102 -> err_pulse.
//   6. RESET=1 mid-LOCKED (async, between clock edges) -> all outputs 0 at once.
//      Then force 300 errors -> err_count stays 255.

Source files
------------

// File: rtl/tick_period_monitor_if.sv
// Signal bundle between a periodic tick source and its health monitor.
// master drives the tick; slave measures it and reports period/lock/error status.
interface tick_period_monitor_if #(
    parameter int CW = 8
);
    logic          tick_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          err_pulse;
    logic [7:0]    err_count;

    modport master (
        output tick_in,
        input  period,
        input  period_valid,
        input  locked,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  tick_in,
        output period,
        output period_valid,
        output locked,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/tick_period_monitor.sv
// Measures cycles between tick_in rising edges, locks after LOCK_COUNT good intervals, counts errors.
// Latency: period/period_valid/locked/err_pulse registered, one cycle after the edge is sampled.
// No backpressure: period_valid and err_pulse are single-cycle strobes that are never held.
module tick_period_monitor #(
    parameter int PERIOD     = 100,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 3,
    parameter int CW         = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    tick_period_monitor_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] GOOD_LO = CW'(PERIOD - TOL);
    localparam logic [CW-1:0] GOOD_HI = CW'(PERIOD + TOL);
    localparam logic [CW-1:0] TMO_CNT = CW'(PERIOD + TOL + 1);
    localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_COUNT);

    logic          tick_q;
    logic [CW-1:0] cnt;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_nxt;
    logic [GW-1:0] good_inc;
    logic          tick_edge;
    logic          good;
    logic          timeout;
    logic          meas;
    logic          err_nxt;

    assign tick_edge = bus.tick_in & ~tick_q;
    assign good      = (cnt >= GOOD_LO) && (cnt <= GOOD_HI);
    // An edge landing on the timeout cycle wins; its interval is out of range anyway.
    assign timeout   = (cnt == TMO_CNT) && !tick_edge;
    assign good_inc  = good_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        meas      = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick_edge) begin
                    state_nxt = S_ACQUIRE;
                    good_nxt  = '0;
                end
            end
            S_ACQUIRE: begin
                if (tick_edge) begin
                    meas = 1'b1;
                    if (good) begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_nxt = S_LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (tick_edge) begin
                    meas = 1'b1;
                    if (!good) begin
                        err_nxt   = 1'b1;
                        good_nxt  = '0;
                        state_nxt = S_ACQUIRE;
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            tick_q   <= 1'b0;
            cnt      <= '0;
            state    <= S_IDLE;
            good_cnt <= '0;
        end else begin
            tick_q   <= bus.tick_in;
            state    <= state_nxt;
            good_cnt <= good_nxt;
            if (tick_edge) begin
                cnt <= CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            bus.period       <= '0;
            bus.period_valid <= 1'b0;
            bus.locked       <= 1'b0;
            bus.err_pulse    <= 1'b0;
            bus.err_count    <= 8'd0;
        end else begin
            bus.period_valid <= meas;
            bus.locked       <= (state_nxt == S_LOCKED);
            bus.err_pulse    <= err_nxt;
            if (meas) begin
                bus.period <= cnt;
            end
            if (err_nxt && (bus.err_count != 8'hFF)) begin
                bus.err_count <= bus.err_count + 8'd1;
            end
        end
    end
endmodule
